// File: rtl/agex_muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer for the AGEX stage.
// Performs shift-add multiply or restoring divide over DBITS iterations.
// Then applies sign correction and high/low or quotient/remainder selection.
// Divide-by-zero and signed-overflow divides bypass the iterations entirely.
module agex_muldiv_seq #(
  parameter int DBITS   = 32,
  parameter int CNTBITS = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [DBITS-1:0] rs1_val,
  input  logic [DBITS-1:0] rs2_val,
  input  logic             flush,
  output logic             ready,
  output logic             stall,
  output logic             done,
  output logic [DBITS-1:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  localparam logic [DBITS-1:0] MIN_NEG = {1'b1, {(DBITS-1){1'b0}}};

  state_t               state;
  logic [CNTBITS-1:0]   count;
  logic [2*DBITS-1:0]   acc;      // mul: {product_hi, multiplier}; div: {remainder, quotient}
  logic [DBITS-1:0]     opb;      // mul: |multiplicand|; div: |divisor|
  logic [2:0]           op_q;
  logic                 neg_q;    // final result must be negated in FIX

  // Operand decode at capture time
  logic             signed_a, signed_b, a_neg, b_neg, neg_in;
  logic [DBITS-1:0] a_abs, b_abs;
  logic             div_zero, div_ovf;
  logic [DBITS-1:0] fast_result;

  always_comb begin
    signed_a    = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    signed_b    = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    a_neg       = signed_a && rs1_val[DBITS-1];
    b_neg       = signed_b && rs2_val[DBITS-1];
    a_abs       = a_neg ? -rs1_val : rs1_val;
    b_abs       = b_neg ? -rs2_val : rs2_val;
    // Remainder takes the dividend's sign; everything else the xor of both
    neg_in      = (op == 3'd6) ? a_neg : (a_neg ^ b_neg);
    div_zero    = op[2] && (rs2_val == '0);
    div_ovf     = ((op == 3'd4) || (op == 3'd6)) && (rs1_val == MIN_NEG) && (rs2_val == '1);
    fast_result = '0;
    if (div_zero) begin
      fast_result = op[1] ? rs1_val : '1;
    end else if (div_ovf) begin
      fast_result = op[1] ? '0 : MIN_NEG;
    end
  end

  // One iteration step of each algorithm
  logic [DBITS:0]     mul_sum;
  logic [2*DBITS-1:0] mul_next;
  logic [DBITS:0]     div_rem;
  logic [DBITS:0]     div_sub;
  logic               div_ge;
  logic [2*DBITS-1:0] div_next;

  always_comb begin
    mul_sum  = {1'b0, acc[2*DBITS-1:DBITS]} + (acc[0] ? {1'b0, opb} : '0);
    mul_next = {mul_sum, acc[DBITS-1:1]};
    div_rem  = acc[2*DBITS-1:DBITS-1];
    div_ge   = div_rem >= {1'b0, opb};
    div_sub  = div_rem - {1'b0, opb};
    div_next = {(div_ge ? div_sub[DBITS-1:0] : div_rem[DBITS-1:0]), acc[DBITS-2:0], div_ge};
  end

  // Sign correction and half/quotient/remainder selection
  logic [2*DBITS-1:0] prod_fix;
  logic [DBITS-1:0]   div_sel;
  logic [DBITS-1:0]   fix_result;

  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    div_sel  = op_q[1] ? acc[2*DBITS-1:DBITS] : acc[DBITS-1:0];
    if (op_q[2]) begin
      fix_result = neg_q ? -div_sel : div_sel;
    end else if (op_q == 3'd0) begin
      fix_result = prod_fix[DBITS-1:0];
    end else begin
      fix_result = prod_fix[2*DBITS-1:DBITS];
    end
  end

  // Stall is combinational so AGEX holds in the accept cycle itself
  assign stall = (start && (state == S_IDLE) && !flush) || (state == S_CALC) || (state == S_FIX);

  // Sequencer FSM with registered ready/done/result
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      ready  <= 1'b1;
      done   <= 1'b0;
      result <= '0;
      count  <= '0;
      acc    <= '0;
      opb    <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start && !flush) begin
            op_q  <= op;
            neg_q <= neg_in;
            ready <= 1'b0;
            if (op[2]) begin
              acc <= {{DBITS{1'b0}}, a_abs};
              opb <= b_abs;
            end else begin
              acc <= {{DBITS{1'b0}}, b_abs};
              opb <= a_abs;
            end
            if (div_zero || div_ovf) begin
              result <= fast_result;
              done   <= 1'b1;
              state  <= S_DONE;
            end else begin
              count <= CNTBITS'(DBITS - 1);
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (flush) begin
            ready <= 1'b1;
            state <= S_IDLE;
          end else begin
            acc <= op_q[2] ? div_next : mul_next;
            if (count == '0) begin
              state <= S_FIX;
            end else begin
              count <= count - 1'b1;
            end
          end
        end
        S_FIX: begin
          if (flush) begin
            ready <= 1'b1;
            state <= S_IDLE;
          end else begin
            result <= fix_result;
            done   <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= S_IDLE;
        end
        default: begin
          ready <= 1'b1;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_agex_muldiv_seq.sv
// Testbench for agex_muldiv_seq: directed RV32M vectors, an arithmetic
// reference model with a cycle-count latency tracker, and per-cycle compare.
module tb_agex_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op_i = 3'd0;
  logic [31:0] a_i = 32'd0;
  logic [31:0] b_i = 32'd0;
  logic        flush = 1'b0;
  logic        ready, stall, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_start = 0;
  bit chk_en = 1'b0;

  agex_muldiv_seq #(.DBITS(32), .CNTBITS(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op_i),
    .rs1_val(a_i), .rs2_val(b_i), .flush(flush),
    .ready(ready), .stall(stall), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Architectural RV32M result computed with plain wide arithmetic
  function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return 32'(sa / sb);
      end
      3'd5: return (b == 32'd0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && ((b == 32'd0) ||
           ((op == 3'd4 || op == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF));
  endfunction

  // Model: cycles remaining until the done cycle, done flag, visible result
  int          m_left = 0;
  bit          m_done = 1'b0;
  logic [31:0] m_result = 32'd0;
  logic [31:0] m_pending = 32'd0;

  always @(posedge clk) begin : model
    int          nl;
    bit          nd;
    logic [31:0] nr;
    logic [31:0] np;
    nl = m_left; nd = m_done; nr = m_result; np = m_pending;
    if (reset) begin
      nl = 0; nd = 1'b0; nr = 32'd0;
    end else if (m_done) begin
      nd = 1'b0;
    end else if (m_left > 0) begin
      if (flush) nl = 0;
      else begin
        nl = m_left - 1;
        if (nl == 0) begin nd = 1'b1; nr = m_pending; end
      end
    end else if (start && !flush) begin
      np = ref_op(op_i, a_i, b_i);
      if (is_fast(op_i, a_i, b_i)) begin nd = 1'b1; nr = np; end
      else nl = 33;   // 32 iterations + 1 correction cycle, done follows
    end
    m_left <= nl; m_done <= nd; m_result <= nr; m_pending <= np;
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      bit idle;
      idle = (m_left == 0) && !m_done;
      check("ready",  32'(ready), 32'(idle));
      check("done",   32'(done),  32'(m_done));
      check("stall",  32'(stall), 32'((m_left > 0) || (idle && start && !flush)));
      check("result", result,     m_result);
    end
  end

  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start = 1'b1; op_i = op; a_i = a; b_i = b;
    t_start = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int lat);
    lat = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done) begin lat = cyc - t_start; break; end
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    launch(op, a, b);
    wait_done(60, lat);
    check({name, "_lat"}, 32'(lat), 32'(exp_lat));
    check({name, "_res"}, result, exp);
    $display("txn %s op=%0d a=%h b=%h result=%h lat=%0d", name, op, a, b, result, lat);
  endtask

  typedef struct { string name; logic [2:0] op; logic [31:0] a, b, exp; int lat; } vec_t;
  vec_t vecs[10];

  initial begin
    int lat;
    vecs[0] = '{"mul",      3'd0, 32'd7,          32'd6,          32'h0000002A, 34};
    vecs[1] = '{"mulh",     3'd1, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000000, 34};
    vecs[2] = '{"mulhu",    3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE, 34};
    vecs[3] = '{"mulhsu",   3'd2, 32'hFFFFFFFF,   32'h00000002,   32'hFFFFFFFF, 34};
    vecs[4] = '{"div",      3'd4, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD, 34};
    vecs[5] = '{"rem",      3'd6, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF, 34};
    vecs[6] = '{"divu_z",   3'd5, 32'd5,          32'd0,          32'hFFFFFFFF, 1};
    vecs[7] = '{"rem_z",    3'd6, 32'd5,          32'd0,          32'h00000005, 1};
    vecs[8] = '{"rem_ovf",  3'd6, 32'h80000000,   32'hFFFFFFFF,   32'h00000000, 1};
    vecs[9] = '{"div_ovf",  3'd4, 32'h80000000,   32'hFFFFFFFF,   32'h80000000, 1};

    // Pin the reference model to hand-computed values
    for (int i = 0; i < 10; i++)
      check({"model_", vecs[i].name}, ref_op(vecs[i].op, vecs[i].a, vecs[i].b), vecs[i].exp);
    check("model_divu_100_3", ref_op(3'd5, 32'd100, 32'd3), 32'd33);

    // Reset state
    repeat (2) @(posedge clk);
    #1; reset = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    chk_en = 1'b1;

    for (int i = 0; i < 10; i++)
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // Flush mid-divide: no done, result keeps the previous value
    launch(3'd5, 32'd100, 32'd3);
    repeat (9) @(posedge clk);
    #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    check("flush_ready", 32'(ready), 32'd1);
    wait_done(40, lat);
    check("flush_no_done", 32'(lat), 32'hFFFFFFFF);
    check("flush_result_kept", result, 32'h80000000);
    $display("txn flush divu a=%h b=%h result=%h done_seen=%0d", 32'd100, 32'd3, result, lat);
    run_op("divu_after_flush", 3'd5, 32'd100, 32'd3, 32'd33, 34);

    // start pulsed during CALC is ignored
    launch(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (4) @(posedge clk);
    #1; start = 1'b1; op_i = 3'd0; a_i = 32'd1; b_i = 32'd1;
    @(posedge clk); #1; start = 1'b0;
    wait_done(60, lat);
    check("busy_start_lat", 32'(lat), 32'd34);
    check("busy_start_res", result, 32'hFFFFFFFE);
    $display("txn busy_start op=3 result=%h lat=%0d", result, lat);

    // start together with flush in IDLE is rejected
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; op_i = 3'd5; a_i = 32'd100; b_i = 32'd3;
    @(negedge clk);
    check("startflush_stall", 32'(stall), 32'd0);
    @(posedge clk); #1; start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("startflush_ready", 32'(ready), 32'd1);
    check("startflush_done", 32'(done), 32'd0);
    $display("txn start_flush ready=%0d stall=%0d", ready, stall);

    // reset in the middle of an operation
    launch(3'd0, 32'd7, 32'd6);
    repeat (4) @(posedge clk);
    #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    check("midrst_ready", 32'(ready), 32'd1);
    check("midrst_stall", 32'(stall), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_result", result, 32'd0);
    wait_done(40, lat);
    check("midrst_no_done", 32'(lat), 32'hFFFFFFFF);
    $display("txn mid_reset result=%h done_seen=%0d", result, lat);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/agex_muldiv_seq.md
Name: agex_muldiv_seq

Overview:
- Multi-cycle sequencer for RV32M multiply/divide operations issued from the AGEX stage.
- Accepts one operation from AGEX, iterates a shift-add multiplier or restoring divider, then returns a 32-bit result.
- While busy, it drives a stall to the FE/DE/AGEX pipeline control.
- A branch redirect in AGEX can flush an in-flight operation.

Parameters:
- DBITS, 32, operand and result width.
- CNTBITS, 6, iteration counter width; must hold DBITS.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  AGEX presents a valid M-extension op this cycle.
- op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rs1_val  in  DBITS  operand A (dividend or multiplicand).
- rs2_val  in  DBITS  operand B (divisor or multiplier).
- flush  in  1  kill the in-flight op (branch mispredict).
- ready  out  1  idle and able to accept start.
- stall  out  1  hold the FE/DE/AGEX latches.
- done  out  1  single-cycle pulse: result valid.
- result  out  DBITS  final result; held until the next accepted start.

Behaviour:
- Clock and reset: single clock domain `clk`. `reset` is synchronous and active-high; it is sampled only on the rising edge of `clk`.
- Reset values: state=IDLE, ready=1, stall=0, done=0, result=0, counter=0, internal accumulators=0.
- States:
  - IDLE
  - CALC (iterations)
  - FIX (sign correction and high/low select)
  - DONE (one cycle; asserts done)
- Acceptance:
  - start is accepted only when state=IDLE and flush=0.
  - Operands and op are captured on the accept edge (cycle T).
  - start while not IDLE is ignored; no queueing.
- stall:
  - Combinational: (start & IDLE & !flush) | CALC | FIX.
  - AGEX therefore holds the instruction from T until done.
  - stall=0 in DONE, so the pipeline advances on the done cycle.
- Signed handling:
  - MULH, MULHSU, DIV and REM take absolute values at capture.
  - The result sign is applied in FIX.
  - MULHSU treats only rs1 as signed.
- Multiply:
  - 2*DBITS-bit product built over DBITS CALC cycles.
  - MUL returns the low half; MULH, MULHSU and MULHU return the high half.
- Divide:
  - Restoring division over DBITS CALC cycles.
  - Quotient sign = sign(A) xor sign(B); remainder sign = sign(A).
- Latency:
  - Accept at edge T → CALC for DBITS cycles → FIX for 1 cycle → DONE.
  - done is high in cycle T+DBITS+2 (34 cycles for DBITS=32).
- Divide-by-zero fast path:
  - If B=0 on a div/rem op: IDLE→DONE directly, done at T+1.
  - DIV/DIVU quotient = all ones; REM/REMU = rs1_val.
- Signed overflow fast path:
  - DIV with A=0x80000000 and B=0xFFFFFFFF: done at T+1, result 0x80000000.
  - REM with the same operands: result 0.
- Counter:
  - Loads DBITS-1 on entry to CALC and decrements each cycle.
  - CALC→FIX when counter==0.
  - No wrap-around is reachable.
- DONE→IDLE unconditionally the next cycle; ready returns to 1 there.
- flush:
  - In CALC or FIX: next state is IDLE, no done, result unchanged, stall drops the next cycle.
  - flush with start in IDLE: start is rejected.
  - flush in DONE: done still pulses (the instruction already committed to AGEX_latch).
- reset mid-operation: immediate return to reset values on that edge; no done.
- result is updated only in the cycle entering DONE.

Test Plan:
- MUL rs1=7, rs2=6 → done at T+34, result=0x0000002A; stall high from T through T+33, low at T+34.
- MULH rs1=0xFFFFFFFF(-1), rs2=0xFFFFFFFF(-1) → result=0x00000000. MULHU with the same operands → result=0xFFFFFFFE.
- DIV rs1=0xFFFFFFF9(-7), rs2=2 → result 0xFFFFFFFD(-3). REM with the same operands → result 0xFFFFFFFF(-1). Both done at T+34.
- Fast paths:
  - DIVU rs1=5, rs2=0 → done at T+1, result 0xFFFFFFFF.
  - REM rs1=5, rs2=0 → result 5.
  - DIV 0x80000000 / 0xFFFFFFFF → result 0x80000000 at T+1.
- Flush: start DIVU 100/3, flush at T+10 → no done; ready=1 at T+11; result keeps its prior value. A new DIVU 100/3 started afterwards → result 33 after 34 cycles.
- Control corner cases:
  - start pulsed during CALC → ignored; first result still correct.
  - reset asserted at T+5 → all outputs return to reset values on the next edge.
  - start+flush in the same IDLE cycle → no acceptance, stall=0.
